// File: rtl/fft_pkg.sv
// Shared FFT defaults and the bit-reversal helper used by the reorder block.
package fft_pkg;

    localparam int unsigned FFT_WIDTH_DEFAULT = 16;
    localparam int unsigned FFT_LOG2N_DEFAULT = 10;

    // Reverses the low 'bits' bits of k; the bits above are returned as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] k, input int unsigned bits);
        logic [31:0] r;
        r = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < bits) begin
                r[5'(i)] = k[5'(bits - 1 - i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: dual-port RAM, synchronous write, asynchronous read.
module fft_reorder_bank
    import fft_pkg::*;
#(
    parameter int unsigned DATA_W = 2 * FFT_WIDTH_DEFAULT,
    parameter int unsigned ADDR_W = FFT_LOG2N_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed FFT output in, natural order out.
// Optional frame-length check on in_last enabled by FFT_REORDER_LASTCHK_EN.
module fft_bitrev_reorder
    import fft_pkg::*;
#(
    parameter int unsigned WIDTH = FFT_WIDTH_DEFAULT,
    parameter int unsigned LOG2N = FFT_LOG2N_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_real,
    input  logic [WIDTH-1:0] in_imag,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_real,
    output logic [WIDTH-1:0] out_imag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last
`ifdef FFT_REORDER_LASTCHK_EN
    ,
    input  logic             in_last,
    output logic             frame_err
`endif
);

    localparam int unsigned DW = 2 * WIDTH;

    logic [LOG2N-1:0] r_wr_cnt;
    logic [LOG2N-1:0] r_rd_cnt;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic [1:0]       r_full;
    logic             r_out_valid;
    logic             r_out_last;
    logic [WIDTH-1:0] r_out_real;
    logic [WIDTH-1:0] r_out_imag;

    logic             w_in_fire;
    logic             w_wr_wrap;
    logic             w_load;
    logic             w_rd_wrap;
    logic [LOG2N-1:0] w_wr_addr;
    logic [1:0]       w_bank_we;
    logic [DW-1:0]    w_bank_rdata [2];
    logic [DW-1:0]    w_rd_data;
    logic [1:0]       w_full_nxt;

    assign in_ready  = !r_full[r_wr_sel];
    assign w_in_fire = in_valid && in_ready;
    assign w_wr_wrap = w_in_fire && (r_wr_cnt == '1);
    assign w_load    = r_full[r_rd_sel] && (!r_out_valid || out_ready);
    assign w_rd_wrap = w_load && (r_rd_cnt == '1);
    assign w_wr_addr = LOG2N'(bitrev(32'(r_wr_cnt), LOG2N));

    assign w_bank_we[0] = w_in_fire && !r_wr_sel;
    assign w_bank_we[1] = w_in_fire && r_wr_sel;
    assign w_rd_data    = w_bank_rdata[r_rd_sel];

    for (genvar g = 0; g < 2; g++) begin : g_bank
        fft_reorder_bank #(
            .DATA_W (DW),
            .ADDR_W (LOG2N)
        ) u_bank (
            .i_clk   (clk),
            .i_we    (w_bank_we[g]),
            .i_waddr (w_wr_addr),
            .i_wdata ({in_real, in_imag}),
            .i_raddr (r_rd_cnt),
            .o_rdata (w_bank_rdata[g])
        );
    end

    // Write side only sets a non-full bank and read side only clears a full one,
    // so a set and a clear on the same edge always address different banks.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_wrap) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
        if (w_rd_wrap) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_cnt    <= '0;
            r_rd_cnt    <= '0;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_full      <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_real  <= '0;
            r_out_imag  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_in_fire) begin
                r_wr_cnt <= r_wr_cnt + LOG2N'(1);
                if (w_wr_wrap) begin
                    r_wr_sel <= !r_wr_sel;
                end
            end
            if (w_load) begin
                r_rd_cnt    <= r_rd_cnt + LOG2N'(1);
                r_out_real  <= w_rd_data[DW-1:WIDTH];
                r_out_imag  <= w_rd_data[WIDTH-1:0];
                r_out_last  <= (r_rd_cnt == '1);
                r_out_valid <= 1'b1;
                if (w_rd_wrap) begin
                    r_rd_sel <= !r_rd_sel;
                end
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign out_real  = r_out_real;
    assign out_imag  = r_out_imag;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

`ifdef FFT_REORDER_LASTCHK_EN
    logic r_frame_err;

    // Sticky: any accepted sample whose in_last disagrees with the frame position.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else if (w_in_fire && (in_last != (r_wr_cnt == '1))) begin
            r_frame_err <= 1'b1;
        end
    end

    assign frame_err = r_frame_err;
`endif

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder: an 8-point and a 1024-point instance.
module tb_fft_bitrev_reorder;

    localparam int NA = 8;
    localparam int NB = 1024;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] a_in_real, a_in_imag, a_out_real, a_out_imag;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last;
    logic [15:0] b_in_real, b_in_imag, b_out_real, b_out_imag;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
`ifdef FFT_REORDER_LASTCHK_EN
    logic        a_in_last, a_frame_err, b_in_last, b_frame_err;
`endif

    int n_cmp = 0;
    int n_err = 0;

    fft_bitrev_reorder #(.WIDTH(16), .LOG2N(3)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_real   (a_in_real),
        .in_imag   (a_in_imag),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .out_real  (a_out_real),
        .out_imag  (a_out_imag),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_last  (a_out_last)
`ifdef FFT_REORDER_LASTCHK_EN
        ,
        .in_last   (a_in_last),
        .frame_err (a_frame_err)
`endif
    );

    fft_bitrev_reorder #(.WIDTH(16), .LOG2N(10)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_real   (b_in_real),
        .in_imag   (b_in_imag),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .out_real  (b_out_real),
        .out_imag  (b_out_imag),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_last  (b_out_last)
`ifdef FFT_REORDER_LASTCHK_EN
        ,
        .in_last   (b_in_last),
        .frame_err (b_frame_err)
`endif
    );

    function automatic int tb_bitrev(input int k, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            if (k[i]) r = r | (1 << (bits - 1 - i));
        end
        return r;
    endfunction

    function automatic logic [15:0] val(input int tag, input int f, input int k, input int n);
        return 16'((tag << 12) + f * n + k);
    endfunction

    task automatic set_b_in(input logic v, input logic [15:0] re, input logic lst);
        b_in_valid = v;
        b_in_real  = re;
        b_in_imag  = re ^ 16'h5A5A;
`ifdef FFT_REORDER_LASTCHK_EN
        b_in_last  = lst;
`else
        if (lst) b_in_imag = re ^ 16'h5A5A;
`endif
    endtask

    task automatic do_reset;
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_real = '0; a_in_imag = '0; a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        set_b_in(1'b0, 16'h0, 1'b0);
`ifdef FFT_REORDER_LASTCHK_EN
        a_in_last = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_cmp++;
        if ({a_out_valid, a_out_last, a_out_real, a_out_imag, a_in_ready} !== {2'b00, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_a got v=%b l=%b re=%h im=%h rdy=%b want 0 0 0 0 1",
                     a_out_valid, a_out_last, a_out_real, a_out_imag, a_in_ready);
        end
        n_cmp++;
        if ({b_out_valid, b_out_last, b_out_real, b_out_imag, b_in_ready} !== {2'b00, 32'h0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_b got v=%b l=%b re=%h im=%h rdy=%b want 0 0 0 0 1",
                     b_out_valid, b_out_last, b_out_real, b_out_imag, b_in_ready);
        end
`ifdef FFT_REORDER_LASTCHK_EN
        n_cmp++;
        if (b_frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL reset_frame_err got %b want 0", b_frame_err);
        end
`endif
    endtask

    // 8-point frame 0..7 must come out as 0,4,2,6,1,5,3,7.
    task automatic test_small_frame;
        int n_in = 0, n_out = 0, cyc = 0, last_acc = -100, first_v = -1;
        logic [15:0] er;
        do_reset;
        while (n_out < NA && cyc < 40) begin
            @(negedge clk);
            if (a_out_valid) begin
                if (first_v < 0) first_v = cyc;
                er = 16'(tb_bitrev(n_out, 3));
                n_cmp++;
                if ({a_out_real, a_out_imag, a_out_last} !== {er, er ^ 16'h5A5A, n_out == NA - 1}) begin
                    n_err++;
                    $display("FAIL small_out n=%0d got re=%h im=%h last=%b want re=%h im=%h last=%b",
                             n_out, a_out_real, a_out_imag, a_out_last, er, er ^ 16'h5A5A,
                             n_out == NA - 1);
                end
                n_out++;
            end
            a_in_valid = (n_in < NA);
            a_in_real  = 16'(n_in);
            a_in_imag  = 16'(n_in) ^ 16'h5A5A;
            if (a_in_valid && a_in_ready) begin
                if (n_in == NA - 1) last_acc = cyc;
                n_in++;
            end
            @(posedge clk);
            cyc++;
        end
        a_in_valid = 1'b0;
        n_cmp++;
        if (n_out != NA) begin
            n_err++;
            $display("FAIL small_count got %0d want %0d", n_out, NA);
        end
        // Valid rises on the edge one cycle after the last accept; seen at the following negedge.
        n_cmp++;
        if (first_v != last_acc + 2) begin
            n_err++;
            $display("FAIL small_latency got first_valid_cycle=%0d want %0d", first_v, last_acc + 2);
        end
    endtask

    task automatic test_back_to_back;
        int n_in = 0, n_out = 0, cyc = 0, in_stall = 0, out_gap = 0, tot = 3 * NB;
        logic [15:0] er;
        do_reset;
        while (n_out < tot && cyc < 5 * NB) begin
            @(negedge clk);
            if (b_out_valid) begin
                er = val(1, n_out / NB, tb_bitrev(n_out % NB, 10), NB);
                n_cmp++;
                if ({b_out_real, b_out_imag, b_out_last} !== {er, er ^ 16'h5A5A, (n_out % NB) == NB - 1}) begin
                    n_err++;
                    $display("FAIL b2b_out n=%0d got re=%h im=%h last=%b want re=%h last=%b",
                             n_out, b_out_real, b_out_imag, b_out_last, er, (n_out % NB) == NB - 1);
                end
                n_out++;
            end else if (n_out > 0) begin
                out_gap++;
            end
            set_b_in(n_in < tot, val(1, n_in / NB, n_in % NB, NB), (n_in % NB) == NB - 1);
            if (b_in_valid) begin
                if (b_in_ready) n_in++;
                else in_stall++;
            end
            @(posedge clk);
            cyc++;
        end
        n_cmp++;
        if (n_out != tot) begin
            n_err++;
            $display("FAIL b2b_count got %0d want %0d", n_out, tot);
        end
        n_cmp++;
        if (in_stall != 0 || out_gap != 0) begin
            n_err++;
            $display("FAIL b2b_idle got in_stall=%0d out_gap=%0d want 0 0", in_stall, out_gap);
        end
    endtask

    task automatic test_stall;
        int n_in = 0, n_out = 0, cyc = 0;
        logic [15:0] er;
        do_reset;
        b_out_ready = 1'b0;
        for (int c = 0; c < 2 * NB + 10; c++) begin
            @(negedge clk);
            if (b_out_valid) begin
                n_cmp++;
                if ({b_out_real, b_out_imag, b_out_last} !== {val(2, 0, 0, NB), val(2, 0, 0, NB) ^ 16'h5A5A, 1'b0}) begin
                    n_err++;
                    $display("FAIL stall_hold cyc=%0d got re=%h last=%b want re=%h last=0",
                             c, b_out_real, b_out_last, val(2, 0, 0, NB));
                end
            end
            set_b_in(1'b1, val(2, n_in / NB, n_in % NB, NB), (n_in % NB) == NB - 1);
            if (b_in_ready) n_in++;
            @(posedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if ({n_in == 2 * NB, b_in_ready, b_out_valid} !== 3'b101) begin
            n_err++;
            $display("FAIL stall_full got accepts=%0d in_ready=%b out_valid=%b want %0d 0 1",
                     n_in, b_in_ready, b_out_valid, 2 * NB);
        end
        set_b_in(1'b0, 16'h0, 1'b0);
        b_out_ready = 1'b1;
        while (n_out < 2 * NB && cyc < 3 * NB) begin
            if (b_out_valid) begin
                er = val(2, n_out / NB, tb_bitrev(n_out % NB, 10), NB);
                n_cmp++;
                if ({b_out_real, b_out_imag, b_out_last} !== {er, er ^ 16'h5A5A, (n_out % NB) == NB - 1}) begin
                    n_err++;
                    $display("FAIL stall_drain n=%0d got re=%h last=%b want re=%h last=%b",
                             n_out, b_out_real, b_out_last, er, (n_out % NB) == NB - 1);
                end
                n_out++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (n_out != 2 * NB || b_in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL stall_drain_done got outs=%0d in_ready=%b want %0d 1", n_out, b_in_ready, 2 * NB);
        end
    endtask

    task automatic test_random_ready;
        int n_in = 0, n_out = 0, cyc = 0, tot = 4 * NB;
        logic prev_stall = 1'b0, v, p_last = 1'b0;
        logic [15:0] er, p_re = '0, p_im = '0;
        do_reset;
        while (n_out < tot && cyc < 16 * NB) begin
            @(negedge clk);
            if (prev_stall) begin
                n_cmp++;
                if ({b_out_valid, b_out_real, b_out_imag, b_out_last} !== {1'b1, p_re, p_im, p_last}) begin
                    n_err++;
                    $display("FAIL rand_stable cyc=%0d got v=%b re=%h im=%h last=%b want 1 %h %h %b",
                             cyc, b_out_valid, b_out_real, b_out_imag, b_out_last, p_re, p_im, p_last);
                end
            end
            b_out_ready = ($urandom_range(0, 2) != 0);
            if (b_out_valid && b_out_ready) begin
                er = val(3, n_out / NB, tb_bitrev(n_out % NB, 10), NB);
                n_cmp++;
                if ({b_out_real, b_out_imag, b_out_last} !== {er, er ^ 16'h5A5A, (n_out % NB) == NB - 1}) begin
                    n_err++;
                    $display("FAIL rand_out n=%0d got re=%h last=%b want re=%h last=%b",
                             n_out, b_out_real, b_out_last, er, (n_out % NB) == NB - 1);
                end
                n_out++;
            end
            prev_stall = b_out_valid && !b_out_ready;
            p_re = b_out_real; p_im = b_out_imag; p_last = b_out_last;
            v = (n_in < tot) && ($urandom_range(0, 3) != 0);
            set_b_in(v, val(3, n_in / NB, n_in % NB, NB), (n_in % NB) == NB - 1);
            if (v && b_in_ready) n_in++;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        n_cmp++;
        if (n_out != tot || b_out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rand_count got outs=%0d trailing_valid=%b want %0d 0", n_out, b_out_valid, tot);
        end
    endtask

    task automatic test_mid_reset;
        int n_in = 0, n_out = 0, cyc = 0;
        logic [15:0] er;
        do_reset;
        b_out_ready = 1'b0;
        while (n_in < NB + 500 && cyc < 3 * NB) begin
            @(negedge clk);
            set_b_in(1'b1, val(4, n_in / NB, n_in % NB, NB), (n_in % NB) == NB - 1);
            if (b_in_ready) n_in++;
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        set_b_in(1'b0, 16'h0, 1'b0);
        n_cmp++;
        if (b_out_valid !== 1'b1 || n_in != NB + 500) begin
            n_err++;
            $display("FAIL midrst_pre got out_valid=%b accepts=%0d want 1 %0d", b_out_valid, n_in, NB + 500);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({b_out_valid, b_in_ready, b_out_last} !== 3'b010) begin
            n_err++;
            $display("FAIL midrst_async got out_valid=%b in_ready=%b last=%b want 0 1 0",
                     b_out_valid, b_in_ready, b_out_last);
        end
        @(negedge clk);
        rst = 1'b0;
        b_out_ready = 1'b1;
        n_in = 0;
        cyc = 0;
        while (n_out < NB && cyc < 3 * NB) begin
            @(negedge clk);
            if (b_out_valid) begin
                er = val(5, 0, tb_bitrev(n_out, 10), NB);
                n_cmp++;
                if ({b_out_real, b_out_imag, b_out_last} !== {er, er ^ 16'h5A5A, n_out == NB - 1}) begin
                    n_err++;
                    $display("FAIL midrst_out n=%0d got re=%h last=%b want re=%h last=%b",
                             n_out, b_out_real, b_out_last, er, n_out == NB - 1);
                end
                n_out++;
            end
            set_b_in(n_in < NB, val(5, 0, n_in, NB), n_in == NB - 1);
            if (b_in_valid && b_in_ready) n_in++;
            @(posedge clk);
            cyc++;
        end
        n_cmp++;
        if (n_out != NB) begin
            n_err++;
            $display("FAIL midrst_count got %0d want %0d", n_out, NB);
        end
    endtask

`ifdef FFT_REORDER_LASTCHK_EN
    task automatic test_lastchk;
        int n_in = 0, n_out = 0, cyc = 0;
        logic chk_next = 1'b0;
        do_reset;
        while (n_out < NB && cyc < 4 * NB) begin
            @(negedge clk);
            if (chk_next) begin
                chk_next = 1'b0;
                n_cmp++;
                if (b_frame_err !== 1'b1) begin
                    n_err++;
                    $display("FAIL lastchk_set got %b want 1", b_frame_err);
                end
            end
            if (b_out_valid) n_out++;
            set_b_in(n_in < NB, val(6, 0, n_in, NB), n_in == 511);
            if (b_in_valid && b_in_ready) begin
                if (n_in == 511) begin
                    n_cmp++;
                    if (b_frame_err !== 1'b0) begin
                        n_err++;
                        $display("FAIL lastchk_before got %b want 0", b_frame_err);
                    end
                    chk_next = 1'b1;
                end
                n_in++;
            end
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        n_cmp++;
        if (b_frame_err !== 1'b1) begin
            n_err++;
            $display("FAIL lastchk_sticky got %b want 1", b_frame_err);
        end
        do_reset;
        n_cmp++;
        if (b_frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL lastchk_clear got %b want 0", b_frame_err);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_small_frame;
        test_back_to_back;
        test_stall;
        test_random_ready;
        test_mid_reset;
`ifdef FFT_REORDER_LASTCHK_EN
        test_lastchk;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
FFT_BITREV_REORDER -- requirements
Module: fft_bitrev_reorder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning signed bit width of each real/imag component.
REQ-002 SHALL have parameter LOG2N, default 10, meaning log2 of frame length N (1024 points).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports in_real, in_imag  input  WIDTH each  signed butterfly-stage output sample, bit-reversed order.
REQ-006 SHALL have port in_valid  input  1  input sample present.
REQ-007 SHALL have port in_ready  output  1  block can accept a sample this cycle.
REQ-008 SHALL have ports out_real, out_imag  output  WIDTH each  signed sample, natural order.
REQ-009 SHALL have port out_valid  output  1  output sample present.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the sample.
REQ-011 SHALL have port out_last  output  1  marks natural index N-1 of each frame.

Function
REQ-012 SHALL transfer on input when in_valid && in_ready, and on output when out_valid && out_ready.
REQ-013 SHALL hold two banks of N entries of 2*WIDTH bits (ping-pong), plus per-bank full flags and separate write-bank and read-bank selects.
REQ-014 SHALL write the k-th accepted sample of a frame (k = 0..N-1, write counter) to address bitrev(k) of the write bank; bitrev reverses the LOG2N address bits.
REQ-015 SHALL, on accepting sample k = N-1, set the write bank's full flag, wrap the write counter to 0 and toggle the write select, all on the same edge.
REQ-016 SHALL drive in_ready = NOT full[write select]; a sample offered to a full bank is not accepted and not lost.
REQ-017 SHALL load the output register from read bank address r (read counter, natural order) when full[read select] && (!out_valid || out_ready).
REQ-018 SHALL assert out_last with the sample at r = N-1.
REQ-019 SHALL, on the load of r = N-1, clear full[read select], wrap r to 0 and toggle the read select.
REQ-020 SHALL present the first sample of a frame one cycle after the edge that accepted its last input, if the output register is free.
REQ-021 SHALL sustain one sample per cycle in both directions when out_ready is held high, with no gap at frame boundaries.
REQ-022 SHALL apply no arithmetic; the data passes through bit-exact.
REQ-023 SHALL hold out_real, out_imag and out_last stable while out_valid && !out_ready.
REQ-024 SHALL let a full-flag set on one bank and a clear on the other bank occur on the same edge; both take effect.

Reset
REQ-025 SHALL clear on rst: out_valid=0, out_last=0, out_real=0, out_imag=0; the write and read counters, both selects and both full flags to 0; so in_ready=1.
REQ-026 SHALL, on rst mid-frame, discard any partial or buffered frames; the next accepted sample is k=0 of bank 0. Bank contents are not reset.

Configuration
REQ-027 SHALL, with macro FFT_REORDER_LASTCHK_EN defined, add input in_last (1 bit) and sticky output frame_err (1 bit, reset 0); frame_err is set when an accepted in_last disagrees with (k == N-1).
REQ-028 SHALL, without FFT_REORDER_LASTCHK_EN, have neither the in_last nor the frame_err port; all other behaviour is identical.

Structure
REQ-029 SHALL take the defaults for WIDTH and LOG2N and a bitrev function from shared package fft_pkg.
REQ-030 SHALL place each bank in sub-module fft_reorder_bank: a dual-port RAM with a synchronous write port and an asynchronous read port.

Verification
REQ-031 SHALL verify (LOG2N=3) inputs 0..7 with out_ready=1 -> outputs 0,4,2,6,1,5,3,7; out_last on 7; first out_valid one cycle after the 8th accept.
REQ-032 SHALL verify (LOG2N=10) ramp 0..1023 for three back-to-back frames -> output n equals bitrev(n); no idle cycles on either side after the first frame.
REQ-033 SHALL verify out_ready=0 while 2N samples are offered -> in_ready falls after 2N accepts; the held output stays at natural index 0 of frame 0 until out_ready rises.
REQ-034 SHALL verify random out_ready toggling over 4 frames -> every sample is delivered exactly once, in order, data stable while stalled.
REQ-035 SHALL verify rst asserted after 500 samples of a frame -> out_valid=0 and in_ready=1 immediately; the next frame outputs correctly.
REQ-036 SHALL verify, with FFT_REORDER_LASTCHK_EN, in_last on sample 511 -> frame_err=1 on the next cycle and it stays set until rst.
